// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first ripple adder, one full-adder cell and a carry flip-flop
module serial_adder #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int CW = $clog2(N) + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]    state;
    logic [N-1:0]  a_sh, b_sh, sum_sh, sum_nx;
    logic          carry, s, carry_nx;
    logic [CW-1:0] cnt;
    // single full-adder cell on the current LSBs; sum bit enters the shift register at the MSB
    always_comb begin
        s        = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nx = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        sum_nx   = (sum_sh >> 1) | (N'(s) << (N - 1));
    end
    assign busy = state == RUN;
    assign done = state == DONE;
    // accept in IDLE or DONE, shift one bit per edge in RUN, publish result only on the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (state != RUN) begin
            if (start) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
                state <= RUN;
            end else begin
                state <= IDLE;
            end
        end else begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nx;
            carry  <= carry_nx;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) begin
                sum   <= sum_nx;
                cout  <= carry_nx;
                state <= DONE;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and sweep checks of serial_adder at N=4, N=1 and N=8
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] st  = '0;
    logic [7:0] a   = '0;
    logic [7:0] b   = '0;
    logic       cin = 1'b0;
    logic       busy4, done4, cout4, busy1, done1, cout1, busy8, done8, cout8;
    logic [3:0] sum4;
    logic [0:0] sum1;
    logic [7:0] sum8;
    logic       bz, dz, cz;
    logic [7:0] sz;
    int vec = 0, mis = 0, sel = 0, acc = 0, dn = 0, d0;
    always #5 clk = ~clk;
    serial_adder #(.N(4)) u4 (.clk(clk), .rst(rst), .start(st[0]), .a(a[3:0]), .b(b[3:0]), .cin(cin),
                              .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));
    serial_adder #(.N(1)) u1 (.clk(clk), .rst(rst), .start(st[1]), .a(a[0:0]), .b(b[0:0]), .cin(cin),
                              .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));
    serial_adder #(.N(8)) u8 (.clk(clk), .rst(rst), .start(st[2]), .a(a), .b(b), .cin(cin),
                              .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
    always_comb begin
        bz = sel == 0 ? busy4 : sel == 1 ? busy1 : busy8;
        dz = sel == 0 ? done4 : sel == 1 ? done1 : done8;
        cz = sel == 0 ? cout4 : sel == 1 ? cout1 : cout8;
        sz = sel == 0 ? {4'b0, sum4} : sel == 1 ? {7'b0, sum1} : sum8;
    end
    always @(negedge clk) dn += int'(done4) + int'(done1) + int'(done8);
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec++;
        if (got !== exp) begin
            mis++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask
    task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic ci);
        a = av;
        b = bv;
        cin = ci;
        st[sel] = 1'b1;
        acc++;
        @(negedge clk);
        st = '0;
    endtask
    task automatic wait_done(input string tag, input logic [7:0] av, input logic [7:0] bv,
                             input logic ci, input int inj);
        int i, nb, w;
        logic [8:0] m, e;
        w = sel == 0 ? 4 : sel == 1 ? 1 : 8;
        m = (9'd1 << w) - 9'd1;
        e = {1'b0, av & m[7:0]} + {1'b0, bv & m[7:0]} + {8'b0, ci};
        i = 0;
        nb = 0;
        while (!dz && i < 40) begin
            if (bz) nb++;
            if (i == inj) begin
                a = 8'h01;
                b = 8'h01;
                cin = 1'b1;
                st[sel] = 1'b1;
            end else st = '0;
            @(negedge clk);
            i++;
        end
        st = '0;
        check({tag, " latency"}, 16'(i), 16'(w));
        check({tag, " busy cycles"}, 16'(nb), 16'(w));
        check({tag, " sum"}, {8'b0, sz}, {7'b0, e & m});
        check({tag, " cout"}, {15'b0, cz}, {15'b0, e[w]});
    endtask
    initial begin
        #2;
        check("rst busy", {15'b0, busy4}, 16'h0);
        check("rst done", {15'b0, done4}, 16'h0);
        check("rst sum", {12'b0, sum4}, 16'h0);
        check("rst cout", {15'b0, cout4}, 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", {15'b0, busy4}, 16'h0);
        check("idle done", {15'b0, done4}, 16'h0);
        check("idle sum", {12'b0, sum4}, 16'h0);
        sel = 0;
        launch(8'h7, 8'h5, 1'b0);
        wait_done("7+5", 8'h7, 8'h5, 1'b0, -1);
        check("7+5 literal sum", {12'b0, sum4}, 16'hC);
        @(negedge clk);
        check("hold done low", {15'b0, done4}, 16'h0);
        check("hold sum", {12'b0, sum4}, 16'hC);
        launch(8'hF, 8'h1, 1'b0);
        wait_done("F+1", 8'hF, 8'h1, 1'b0, -1);
        check("F+1 literal", {11'b0, cout4, sum4}, 16'h10);
        repeat (3) @(negedge clk);
        check("hold F+1", {11'b0, cout4, sum4}, 16'h10);
        launch(8'hF, 8'hF, 1'b1);
        wait_done("F+F+1", 8'hF, 8'hF, 1'b1, -1);
        check("F+F+1 literal", {11'b0, cout4, sum4}, 16'h1F);
        launch(8'h7, 8'h5, 1'b0);
        wait_done("ignore start", 8'h7, 8'h5, 1'b0, 1);
        launch(8'h3, 8'h4, 1'b1);
        wait_done("back2back", 8'h3, 8'h4, 1'b1, -1);
        check("back2back literal", {11'b0, cout4, sum4}, 16'h08);
        @(negedge clk);
        check("one done only", {15'b0, done4}, 16'h0);
        d0 = dn;
        launch(8'hA, 8'h6, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", {15'b0, busy4}, 16'h0);
        check("async rst sum", {12'b0, sum4}, 16'h0);
        check("async rst cout", {15'b0, cout4}, 16'h0);
        acc--;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("no done after rst", 16'(dn), 16'(d0));
        launch(8'hA, 8'h6, 1'b0);
        wait_done("A+6", 8'hA, 8'h6, 1'b0, -1);
        check("A+6 literal", {11'b0, cout4, sum4}, 16'h10);
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++) begin
                    launch(8'(x), 8'(y), 1'(c));
                    wait_done("n4 sweep", 8'(x), 8'(y), 1'(c), -1);
                end
        sel = 1;
        launch(8'h1, 8'h1, 1'b1);
        wait_done("n1 1+1+1", 8'h1, 8'h1, 1'b1, -1);
        check("n1 literal", {14'b0, cout1, sum1}, 16'h3);
        for (int c = 0; c < 8; c++) begin
            launch(8'(c & 1), 8'((c >> 1) & 1), 1'(c >> 2));
            wait_done("n1 sweep", 8'(c & 1), 8'((c >> 1) & 1), 1'(c >> 2), -1);
        end
        sel = 2;
        launch(8'hFF, 8'h01, 1'b0);
        wait_done("n8 FF+1", 8'hFF, 8'h01, 1'b0, -1);
        check("n8 literal", {7'b0, cout8, sum8}, 16'h100);
        for (int k = 0; k < 1000; k++) begin
            logic [7:0] ra, rb;
            logic rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            launch(ra, rb, rc);
            wait_done("n8 random", ra, rb, rc, -1);
        end
        repeat (3) @(negedge clk);
        check("done count", 16'(dn), 16'(acc));
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
